hex_ascii_tx_serializer: RTL and testbench
==========================================

# hex_ascii_tx_serializer

Converts a binary word into a stream of ASCII hexadecimal characters, most-significant nibble first, and hands them one at a time to the UART transmitter over a valid/ready byte handshake. It is the transmit-side counterpart of the receive-path ASCII-to-hex decoder. It sits between the register/data source and the UART TX byte interface, so the controller can echo or report values as readable hex text.

## Interface
Parameters:
- `NIBBLES`, default 4: number of hex digits per word. Input word width is 4*`NIBBLES`. Legal range is 1..8.
- `UPPER`, default 1: 1 emits letters A–F as 0x41–0x46; 0 emits a–f as 0x61–0x66.

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `DATA` in 4*`NIBBLES`: word to print. Sampled only when a start is accepted.
- `START` in 1: request to print `DATA`. Accepted on a rising edge where `START`=1 and `BUSY`=0.
- `BUSY` out 1: high while a sequence is in progress.
- `TX_DATA` out 8: current ASCII character.
- `TX_VALID` out 1: `TX_DATA` is valid.
- `TX_READY` in 1: the UART TX accepts the byte.
- `DONE` out 1: one-cycle pulse when the last character has been accepted.

## Operation
- Reset (`RST_N`=0 at an edge) gives: state IDLE; `BUSY`=0, `TX_VALID`=0, `TX_DATA`=8'h00, `DONE`=0; shift register and counter cleared. Reset has priority over every other input, including mid-sequence. An aborted sequence produces no `DONE` and no further characters.
- States:
  - IDLE: no character is offered.
  - DIGIT: offers the current hex digit.
  - CR: only when the macro is defined.
  - LF: only when the macro is defined.
- IDLE → DIGIT on an accepted start:
  - capture `DATA` into the shift register;
  - set the digit counter to `NIBBLES`-1;
  - set `BUSY`=1 and `TX_VALID`=1;
  - drive `TX_DATA` with the encoding of the top nibble.
- Encoding:
  - nibble n in 0..9 → 8'h30+n;
  - nibble n in 10..15 → 8'h41+(n-10) when `UPPER`=1, or 8'h61+(n-10) when `UPPER`=0.
- Handshake:
  - A byte transfers on an edge where `TX_VALID`=1 and `TX_READY`=1.
  - While `TX_VALID`=1 and `TX_READY`=0, `TX_DATA` holds stable and `TX_VALID` stays high.
  - `TX_VALID` never drops without a transfer, except on reset.
- DIGIT transfer:
  - If the counter is nonzero: shift the register left by 4, decrement the counter, and present the next digit on the following cycle.
  - If the counter is 0: go to CR when the macro is defined, otherwise complete.
- CR transfer → LF. LF transfer → complete.
- Complete: go to IDLE with `BUSY`=0 and `TX_VALID`=0, and pulse `DONE`=1 for exactly one cycle.
- `START` while `BUSY`=1 is ignored. It is not queued, and `DATA` changes have no effect during a sequence.
- `START` during the `DONE` cycle is accepted, because `BUSY`=0 then.
- `TX_READY` while `TX_VALID`=0 has no effect.

## Timing
- Start accepted at edge k → first character valid in cycle k+1. Latency is one cycle.
- With `TX_READY` held at 1, each character transfers in one cycle. A sequence of C characters transfers on edges k+1..k+C.
- C = `NIBBLES`, or `NIBBLES`+2 with the macro defined.
- `DONE` and `BUSY`=0 both appear in cycle k+C+1.
- Back-to-back: a start accepted in the `DONE` cycle puts its first character out one cycle later. This gives a one-cycle `TX_VALID` gap between words.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `HEX_ASCII_CRLF_EN`:
  - When defined, every word is followed by 8'h0D (CR) and then 8'h0A (LF), and `DONE` waits for the LF transfer.
  - When undefined, the CR and LF states are not built, and `DONE` follows the last digit transfer.

## Test plan
- Basic word: `NIBBLES`=4, `DATA`=16'h1A2F, `START` pulse, `TX_READY`=1 → `TX_DATA` 0x31, 0x41, 0x32, 0x46 on four consecutive transfers, then a one-cycle `DONE`. With `HEX_ASCII_CRLF_EN`, 0x0D and 0x0A follow before `DONE`.
- Backpressure: start with `DATA`=16'h1A2F and hold `TX_READY`=0 for 3 cycles → `TX_VALID`=1 and `TX_DATA`=0x31 stable for all 3 cycles. The full sequence then completes with no duplicate or dropped characters.
- Start while busy: during a 16'h1A2F sequence, assert `START` with `DATA`=16'hFFFF → ignored. The output stays 0x31, 0x41, 0x32, 0x46, and only one `DONE` pulse occurs.
- Lowercase: `UPPER`=0, `DATA`=16'hBEEF → 0x62, 0x65, 0x65, 0x66.
- Mid-sequence reset: `RST_N`=0 for one edge after 2 characters have transferred → next cycle `TX_VALID`=0, `BUSY`=0, `DONE`=0, `TX_DATA`=0x00, with no further characters. A following start with 16'h0009 gives 0x30, 0x30, 0x30, 0x39.
- Back-to-back: `DATA`=16'h0000, then re-assert `START` in the `DONE` cycle with 16'hC0DE → 0x30 ×4, exactly one idle `TX_VALID` cycle, then 0x43, 0x30, 0x44, 0x45.

Source files
------------

// File: rtl/hex_ascii_tx_serializer_if.sv
// Byte-stream bundle between a word source, the hex/ASCII serializer and a UART TX.
// DATA/START come from the source; TX_* is the valid/ready byte link to the UART.
interface hex_ascii_tx_serializer_if #(
    parameter int unsigned NIBBLES = 4
);
    logic [4*NIBBLES-1:0] DATA;
    logic                 START;
    logic                 BUSY;
    logic [7:0]           TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic                 DONE;

    modport master (
        output DATA, START, TX_READY,
        input  BUSY, TX_DATA, TX_VALID, DONE
    );

    modport slave (
        input  DATA, START, TX_READY,
        output BUSY, TX_DATA, TX_VALID, DONE
    );
endinterface

// File: rtl/hex_ascii_tx_serializer.sv
// Prints a binary word as ASCII hex digits (MS nibble first) over a valid/ready byte link.
// Optional HEX_ASCII_CRLF_EN appends CR, LF after every word.
module hex_ascii_tx_serializer #(
    parameter int unsigned NIBBLES = 4,
    parameter bit          UPPER   = 1'b1
) (
    input logic                      CLK,
    input logic                      RST_N,
    hex_ascii_tx_serializer_if.slave bus
);
    localparam int unsigned W = 4 * NIBBLES;

`ifdef HEX_ASCII_CRLF_EN
    typedef enum logic [1:0] {StIdle, StDigit, StCr, StLf} state_e;
`else
    typedef enum logic [0:0] {StIdle, StDigit} state_e;
`endif

    state_e         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           finish;

    function automatic logic [7:0] encode(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        finish     = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.START) begin
                    shreg_d    = bus.DATA;
                    cnt_d      = 3'(NIBBLES - 1);
                    busy_d     = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = encode(bus.DATA[W-1 -: 4]);
                    state_d    = StDigit;
                end
            end
            StDigit: begin
                if (bus.TX_READY) begin
                    if (cnt_q != 3'd0) begin
                        shreg_d   = shreg_q << 4;
                        cnt_d     = cnt_q - 3'd1;
                        tx_data_d = encode(shreg_d[W-1 -: 4]);
                    end else begin
`ifdef HEX_ASCII_CRLF_EN
                        tx_data_d = 8'h0D;
                        state_d   = StCr;
`else
                        finish = 1'b1;
`endif
                    end
                end
            end
`ifdef HEX_ASCII_CRLF_EN
            StCr: begin
                if (bus.TX_READY) begin
                    tx_data_d = 8'h0A;
                    state_d   = StLf;
                end
            end
            StLf: begin
                if (bus.TX_READY) begin
                    finish = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Completion leaves TX_DATA holding the last byte; only TX_VALID matters.
        if (finish) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.TX_DATA  = tx_data_q;
    assign bus.TX_VALID = tx_valid_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
endmodule

// File: tb/tb_hex_ascii_tx_serializer.sv
// Directed bench for hex_ascii_tx_serializer: uppercase and lowercase instances, NIBBLES=4.
// Honours HEX_ASCII_CRLF_EN by appending CR/LF to the expected streams.
module tb_hex_ascii_tx_serializer;
`ifdef HEX_ASCII_CRLF_EN
    localparam int C_CHARS = 6;
`else
    localparam int C_CHARS = 4;
`endif

    logic clk;
    logic rst_n;
    logic ready;

    hex_ascii_tx_serializer_if #(.NIBBLES(4)) if_up ();
    hex_ascii_tx_serializer_if #(.NIBBLES(4)) if_lo ();

    assign if_up.TX_READY = ready;
    assign if_lo.TX_READY = ready;

    hex_ascii_tx_serializer #(.NIBBLES(4), .UPPER(1'b1)) u_up (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (if_up.slave)
    );

    hex_ascii_tx_serializer #(.NIBBLES(4), .UPPER(1'b0)) u_lo (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (if_lo.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_fail;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         dones;
    int         done_at;
    logic       busy_at_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_valid(input bit lo);
        return lo ? if_lo.TX_VALID : if_up.TX_VALID;
    endfunction
    function automatic logic [7:0] cur_data(input bit lo);
        return lo ? if_lo.TX_DATA : if_up.TX_DATA;
    endfunction
    function automatic logic cur_done(input bit lo);
        return lo ? if_lo.DONE : if_up.DONE;
    endfunction
    function automatic logic cur_busy(input bit lo);
        return lo ? if_lo.BUSY : if_up.BUSY;
    endfunction

    task automatic add_crlf();
`ifdef HEX_ASCII_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic set_exp(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        add_crlf();
    endtask

    // Drives a one-cycle start; returns at the sample point of cycle k+1.
    task automatic do_start(input bit lo, input logic [15:0] d);
        if (lo) begin
            if_lo.DATA  = d;
            if_lo.START = 1'b1;
        end else begin
            if_up.DATA  = d;
            if_up.START = 1'b1;
        end
        tick();
        if_up.START = 1'b0;
        if_lo.START = 1'b0;
    endtask

    // Runs a fixed number of cycles recording transferred bytes and DONE pulses.
    task automatic run_seq(input bit lo, input int cycles, input int hold_start);
        got.delete();
        dones        = 0;
        done_at      = -1;
        busy_at_done = 1'bx;
        for (int c = 0; c < cycles; c++) begin
            if (c == hold_start) begin
                if_up.START = 1'b0;
                if_lo.START = 1'b0;
            end
            if (cur_valid(lo) && ready) got.push_back(cur_data(lo));
            tick();
            if (cur_done(lo)) begin
                dones++;
                if (done_at < 0) begin
                    done_at      = c + 1;
                    busy_at_done = cur_busy(lo);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (if_up.BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", if_up.BUSY);
        end
        n_checks++;
        if (if_up.TX_VALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", if_up.TX_VALID);
        end
        n_checks++;
        if (if_up.TX_DATA !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00", if_up.TX_DATA);
        end
        n_checks++;
        if (if_up.DONE !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b expected 0", if_up.DONE);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        do_start(1'b0, 16'h1A2F);
        n_checks++;
        if (if_up.TX_VALID !== 1'b1 || if_up.TX_DATA !== 8'h31 || if_up.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%b data=%h busy=%b expected 1/31/1",
                     if_up.TX_VALID, if_up.TX_DATA, if_up.BUSY);
        end
        run_seq(1'b0, 10, 0);
        set_exp(8'h31, 8'h41, 8'h32, 8'h46);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_char%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (dones != 1 || done_at != C_CHARS || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: count=%0d at=%0d busy=%b expected 1/%0d/0",
                     dones, done_at, busy_at_done, C_CHARS);
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        do_start(1'b0, 16'h1A2F);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (if_up.TX_VALID !== 1'b1 || if_up.TX_DATA !== 8'h31) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h expected 1/31",
                         i, if_up.TX_VALID, if_up.TX_DATA);
            end
            if (i < 2) tick();
        end
        ready = 1'b1;
        run_seq(1'b0, 10, 0);
        set_exp(8'h31, 8'h41, 8'h32, 8'h46);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_char%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", dones);
        end
    endtask

    task automatic test_start_while_busy();
        ready = 1'b1;
        do_start(1'b0, 16'h1A2F);
        if_up.DATA  = 16'hFFFF;
        if_up.START = 1'b1;
        run_seq(1'b0, 12, 2);
        set_exp(8'h31, 8'h41, 8'h32, 8'h46);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL busy_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL busy_char%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL busy_done: got %0d pulses expected 1", dones);
        end
    endtask

    task automatic test_lowercase();
        ready = 1'b1;
        do_start(1'b1, 16'hBEEF);
        run_seq(1'b1, 10, 0);
        set_exp(8'h62, 8'h65, 8'h65, 8'h66);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL lower_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL lower_char%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL lower_done: got %0d pulses expected 1", dones);
        end
    endtask

    task automatic test_mid_reset();
        ready = 1'b1;
        do_start(1'b0, 16'h1A2F);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (if_up.TX_VALID !== 1'b0 || if_up.BUSY !== 1'b0 || if_up.DONE !== 1'b0 ||
            if_up.TX_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b busy=%b done=%b data=%h expected 0/0/0/00",
                     if_up.TX_VALID, if_up.BUSY, if_up.DONE, if_up.TX_DATA);
        end
        run_seq(1'b0, 8, 0);
        n_checks++;
        if (got.size() != 0 || dones != 0) begin
            n_fail++;
            $display("FAIL rst_quiet: chars=%0d dones=%0d expected 0/0", got.size(), dones);
        end
        do_start(1'b0, 16'h0009);
        run_seq(1'b0, 10, 0);
        set_exp(8'h30, 8'h30, 8'h30, 8'h39);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rst_len: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rst_char%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen_done;
        ready     = 1'b1;
        seen_done = 1'b0;
        do_start(1'b0, 16'h0000);
        got.delete();
        for (int c = 0; c < 12 && !seen_done; c++) begin
            if (if_up.TX_VALID) got.push_back(if_up.TX_DATA);
            tick();
            if (if_up.DONE) seen_done = 1'b1;
        end
        n_checks++;
        if (!seen_done) begin
            n_fail++; $display("FAIL b2b_timeout: no DONE within 12 cycles, expected 1 pulse");
        end
        set_exp(8'h30, 8'h30, 8'h30, 8'h30);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_len1: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b1_char%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (if_up.TX_VALID !== 1'b0 || if_up.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: valid=%b busy=%b expected 0/0", if_up.TX_VALID, if_up.BUSY);
        end
        do_start(1'b0, 16'hC0DE);
        n_checks++;
        if (if_up.TX_VALID !== 1'b1 || if_up.TX_DATA !== 8'h43) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b data=%h expected 1/43",
                     if_up.TX_VALID, if_up.TX_DATA);
        end
        run_seq(1'b0, 10, 0);
        set_exp(8'h43, 8'h30, 8'h44, 8'h45);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_len2: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b2_char%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL b2b_done: got %0d pulses expected 1", dones);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        ready       = 1'b0;
        if_up.DATA  = '0;
        if_up.START = 1'b0;
        if_lo.DATA  = '0;
        if_lo.START = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_lowercase();
        test_mid_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
